// File: rtl/wb_epb_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_epb_master
// Purpose  : Wishbone-slave to EPB-master bridge. Each 8-bit Wishbone access
//            becomes one EPB bus cycle (chip select, read/write strobe, wait
//            for peripheral ready). Single clock: the EPB peripheral clock.
// Options  : WB_EPB_MASTER_TIMEOUT_EN - bound the wait for epb_rdy_i to
//            TIMEOUT strobe cycles; a timed-out read returns 8'hFF and
//            timeout_o pulses alongside wb_ack_o.
// Revision : 1.0 - initial release
// ============================================================================
module wb_epb_master #(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int TIMEOUT      = 255,
  parameter int TO_W         = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [5:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       epb_cs_n,
  output logic       epb_oe_n,
  output logic       epb_we_n,
  output logic [5:0] epb_addr,
  output logic [7:0] epb_data_o,
  output logic       epb_data_oe,
  input  logic [7:0] epb_data_i,
  input  logic       epb_rdy_i,
  output logic       busy_o,
  output logic       timeout_o
);

  // Phase counter is shared by SETUP and HOLD; it only ever holds N-1..0.
  localparam int PH_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  // Reject parameter sets that would make the phase or timeout counters wrap.
  if (SETUP_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT < 1 || TO_W < 1 ||
      TO_W > 30 || TIMEOUT >= (1 << TO_W)) begin : g_bad_cfg
    $error("wb_epb_master: invalid parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  state_t            state_q;
  logic [PH_W-1:0]   ph_q;
  logic              we_q;
  logic              cs_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic [5:0]        addr_q;
  logic [7:0]        wdat_q;
  logic              data_oe_q;
  logic              ack_q;
  logic [7:0]        rdat_q;
  logic              busy_q;

`ifdef WB_EPB_MASTER_TIMEOUT_EN
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0]   to_cnt_q;
  logic              to_flag_q;
  logic              timeout_q;
`endif

  // Bus-cycle sequencer; every output is a register written only here.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      we_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      addr_q    <= '0;
      wdat_q    <= '0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      busy_q    <= 1'b0;
`ifdef WB_EPB_MASTER_TIMEOUT_EN
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
      timeout_q <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef WB_EPB_MASTER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            addr_q    <= wb_adr_i;
            wdat_q    <= wb_dat_i;
            we_q      <= wb_we_i;
            cs_n_q    <= 1'b0;
            data_oe_q <= wb_we_i;
            ph_q      <= PH_W'(SETUP_CYCLES - 1);
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_q == '0) begin
            if (we_q) we_n_q <= 1'b0;
            else      oe_n_q <= 1'b0;
`ifdef WB_EPB_MASTER_TIMEOUT_EN
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
`endif
            state_q <= ST_STROBE;
          end else begin
            ph_q <= ph_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (epb_rdy_i) begin
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if (!we_q) rdat_q <= epb_data_i;
            ph_q    <= PH_W'(HOLD_CYCLES - 1);
            state_q <= ST_HOLD;
          end
`ifdef WB_EPB_MASTER_TIMEOUT_EN
          // Last permitted strobe cycle without ready: abandon the wait.
          else if (to_cnt_q == C_TO_LAST) begin
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if (!we_q) rdat_q <= 8'hFF;
            to_flag_q <= 1'b1;
            ph_q      <= PH_W'(HOLD_CYCLES - 1);
            state_q   <= ST_HOLD;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          if (ph_q == '0) begin
            cs_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            // Ack is registered, so the master's cyc/stb on the last hold
            // cycle decides whether the ack cycle carries an acknowledge.
            ack_q     <= wb_cyc_i && wb_stb_i;
`ifdef WB_EPB_MASTER_TIMEOUT_EN
            timeout_q <= to_flag_q && wb_cyc_i && wb_stb_i;
`endif
            state_q   <= ST_ACK;
          end else begin
            ph_q <= ph_q - 1'b1;
          end
        end
        ST_ACK: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o    = rdat_q;
  assign wb_ack_o    = ack_q;
  assign epb_cs_n    = cs_n_q;
  assign epb_oe_n    = oe_n_q;
  assign epb_we_n    = we_n_q;
  assign epb_addr    = addr_q;
  assign epb_data_o  = wdat_q;
  assign epb_data_oe = data_oe_q;
  assign busy_o      = busy_q;
`ifdef WB_EPB_MASTER_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_epb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_epb_master
// Purpose  : Directed self-checking bench for wb_epb_master (defaults, with
//            TIMEOUT=16 so the timeout build can be exercised quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_epb_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cyc, stb, we;
  logic [5:0] adr;
  logic [7:0] dat_w;
  logic [7:0] epb_di;
  logic       rdy;
  wire  [7:0] dat_o;
  wire        ack;
  wire        cs_n, oe_n, we_n;
  wire  [5:0] addr;
  wire  [7:0] epb_do;
  wire        data_oe;
  wire        busy;
  wire        tmo;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_epb_master #(
    .SETUP_CYCLES (1),
    .HOLD_CYCLES  (1),
    .TIMEOUT      (16),
    .TO_W         (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_w),
    .wb_dat_o    (dat_o),
    .wb_ack_o    (ack),
    .epb_cs_n    (cs_n),
    .epb_oe_n    (oe_n),
    .epb_we_n    (we_n),
    .epb_addr    (addr),
    .epb_data_o  (epb_do),
    .epb_data_oe (data_oe),
    .epb_data_i  (epb_di),
    .epb_rdy_i   (rdy),
    .busy_o      (busy),
    .timeout_o   (tmo)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {cs_n,oe_n,we_n,data_oe,ack,busy,tmo,addr,epb_do,dat_o}
  localparam logic [28:0] RST_VEC = {7'b1110000, 6'd0, 8'd0, 8'd0};

  task automatic test_reset();
    logic [28:0] obs;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    epb_di = '0; rdy = 1'b0;
    tick();
    obs = {cs_n, oe_n, we_n, data_oe, ack, busy, tmo, addr, epb_do, dat_o};
    vecs++;
    if (obs !== RST_VEC) begin
      errs++; $display("FAIL reset_init: got %h want %h", obs, RST_VEC);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    // Start a read that stalls in STROBE, then reset it.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h07; dat_w = 8'h33; rdy = 1'b0;
    tick(); tick();
    vecs++;
    if ({cs_n, oe_n, busy} !== 3'b001) begin
      errs++; $display("FAIL reset_pre_strobe: got %b want 001", {cs_n, oe_n, busy});
    end
    tick();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    tick();
    obs = {cs_n, oe_n, we_n, data_oe, ack, busy, tmo, addr, epb_do, dat_o};
    vecs++;
    if (obs !== RST_VEC) begin
      errs++; $display("FAIL reset_mid_strobe: got %h want %h", obs, RST_VEC);
    end
    tick(); tick();
    vecs++;
    if ({ack, busy, cs_n} !== 3'b001) begin
      errs++; $display("FAIL reset_hold: got %b want 001", {ack, busy, cs_n});
    end
    rst = 1'b0;
    tick();
    vecs++;
    if ({ack, busy, cs_n} !== 3'b001) begin
      errs++; $display("FAIL reset_release: got %b want 001", {ack, busy, cs_n});
    end
  endtask

  task automatic test_write();
    rdy = 1'b1; epb_di = 8'h00;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'h15; dat_w = 8'hA5;
    tick(); // N+1
    vecs++;
    if ({cs_n, oe_n, we_n, data_oe, ack, busy, addr, epb_do} !== {6'b011101, 6'h15, 8'hA5}) begin
      errs++; $display("FAIL write_n1: got %b %h %h want 011101 15 a5",
                       {cs_n, oe_n, we_n, data_oe, ack, busy}, addr, epb_do);
    end
    tick(); // N+2
    vecs++;
    if ({cs_n, oe_n, we_n, data_oe, ack} !== 5'b01010) begin
      errs++; $display("FAIL write_n2: got %b want 01010", {cs_n, oe_n, we_n, data_oe, ack});
    end
    tick(); // N+3
    vecs++;
    if ({cs_n, oe_n, we_n, data_oe, ack, addr, epb_do} !== {5'b01110, 6'h15, 8'hA5}) begin
      errs++; $display("FAIL write_n3: got %b %h %h want 01110 15 a5",
                       {cs_n, oe_n, we_n, data_oe, ack}, addr, epb_do);
    end
    tick(); // N+4
    vecs++;
    if ({cs_n, oe_n, we_n, data_oe, ack, busy, tmo} !== 7'b1110110) begin
      errs++; $display("FAIL write_ack: got %b want 1110110", {cs_n, oe_n, we_n, data_oe, ack, busy, tmo});
    end
    cyc = 1'b0; stb = 1'b0;
    tick(); // N+5
    vecs++;
    if ({ack, busy, cs_n} !== 3'b001) begin
      errs++; $display("FAIL write_idle: got %b want 001", {ack, busy, cs_n});
    end
  endtask

  task automatic test_read_wait();
    int  n = 0;
    int  bad_oe = 0;
    bit  got = 1'b0;
    rdy = 1'b0; epb_di = 8'hA3;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h3F; dat_w = 8'h00;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!oe_n) n++;
      if (data_oe !== 1'b0) bad_oe++;
      if (ack) begin
        got = 1'b1;
        vecs++;
        if ({dat_o, cs_n, tmo} !== {8'h5C, 2'b10}) begin
          errs++; $display("FAIL read_ack_data: got %h %b want 5c 10", dat_o, {cs_n, tmo});
        end
        break;
      end
      if (n == 1 && !oe_n) begin
        vecs++;
        if (addr !== 6'h3F) begin
          errs++; $display("FAIL read_addr: got %h want 3f", addr);
        end
      end
      rdy    = (n == 6);
      epb_di = (n == 6) ? 8'h5C : 8'hA3;
    end
    vecs++;
    if (!got) begin
      errs++; $display("FAIL read_ack_seen: got 0 want 1");
    end
    vecs++;
    if (n !== 6) begin
      errs++; $display("FAIL read_strobe_len: got %0d want 6", n);
    end
    vecs++;
    if (bad_oe !== 0) begin
      errs++; $display("FAIL read_data_oe: got %0d cycles with data_oe=1 want 0", bad_oe);
    end
    cyc = 1'b0; stb = 1'b0; rdy = 1'b0;
    tick();
    vecs++;
    if ({ack, busy} !== 2'b00) begin
      errs++; $display("FAIL read_idle: got %b want 00", {ack, busy});
    end
  endtask

  task automatic test_back_to_back();
    int   phase = 0;
    int   falls = 0;
    int   acks = 0;
    int   high_run = 0;
    int   gap = -1;
    logic prev_cs = 1'b1;
    bit   wr_ok = 1'b0;
    rdy = 1'b1; epb_di = 8'h3C;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h01; dat_w = 8'h00;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (prev_cs && !cs_n) begin
        falls++;
        if (falls == 2) gap = high_run;
      end
      if (cs_n) high_run++; else high_run = 0;
      prev_cs = cs_n;
      if (!we_n && data_oe && addr == 6'h2A && epb_do == 8'h69) wr_ok = 1'b1;
      if (ack) begin
        acks++;
        if (phase == 0) begin
          vecs++;
          if (dat_o !== 8'h3C) begin
            errs++; $display("FAIL b2b_read_data: got %h want 3c", dat_o);
          end
          we = 1'b1; adr = 6'h2A; dat_w = 8'h69;
          phase = 1;
        end else begin
          cyc = 1'b0; stb = 1'b0;
          phase = 2;
        end
      end
    end
    vecs++;
    if ({falls, acks} !== {32'd2, 32'd2}) begin
      errs++; $display("FAIL b2b_counts: got cycles=%0d acks=%0d want 2 2", falls, acks);
    end
    vecs++;
    if (gap < 2) begin
      errs++; $display("FAIL b2b_cs_gap: got %0d want >=2", gap);
    end
    vecs++;
    if (!wr_ok) begin
      errs++; $display("FAIL b2b_write_strobe: got 0 want 1");
    end
    vecs++;
    if ({dat_o, busy} !== {8'h3C, 1'b0}) begin
      errs++; $display("FAIL b2b_end: got %h %b want 3c 0", dat_o, busy);
    end
  endtask

  task automatic test_drop_stb();
    int cs_low = 0;
    int we_low = 0;
    int acks = 0;
    int tmos = 0;
    rdy = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'h0A; dat_w = 8'h5A;
    tick(); // SETUP
    vecs++;
    if ({cs_n, busy} !== 2'b01) begin
      errs++; $display("FAIL drop_setup: got %b want 01", {cs_n, busy});
    end
    cs_low = 1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!cs_n) cs_low++;
      if (!we_n) we_low++;
      if (ack) acks++;
      if (tmo) tmos++;
    end
    vecs++;
    if ({cs_low, we_low, acks, tmos} !== {32'd3, 32'd1, 32'd0, 32'd0}) begin
      errs++; $display("FAIL drop_cycle: got cs=%0d we=%0d ack=%0d to=%0d want 3 1 0 0",
                       cs_low, we_low, acks, tmos);
    end
    vecs++;
    if ({busy, cs_n, data_oe} !== 3'b010) begin
      errs++; $display("FAIL drop_idle: got %b want 010", {busy, cs_n, data_oe});
    end
  endtask

`ifdef WB_EPB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int early = 0;
    bit got = 1'b0;
    rdy = 1'b0; epb_di = 8'h12;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h11;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!oe_n) n++;
      if (tmo && !ack) early++;
      if (ack) begin
        got = 1'b1;
        vecs++;
        if ({dat_o, tmo} !== {8'hFF, 1'b1}) begin
          errs++; $display("FAIL timeout_ack: got %h %b want ff 1", dat_o, tmo);
        end
        break;
      end
    end
    vecs++;
    if ({got, n, early} !== {1'b1, 32'd16, 32'd0}) begin
      errs++; $display("FAIL timeout_len: got seen=%0d strobe=%0d stray=%0d want 1 16 0", got, n, early);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    vecs++;
    if ({tmo, ack, busy} !== 3'b000) begin
      errs++; $display("FAIL timeout_pulse: got %b want 000", {tmo, ack, busy});
    end
  endtask
`else
  task automatic test_long_wait();
    int n = 0;
    int bad = 0;
    bit got = 1'b0;
    rdy = 1'b0; epb_di = 8'h81;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h22;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!oe_n) n++;
      if (ack || tmo) bad++;
    end
    vecs++;
    if ({n, bad, 31'd0, busy} !== {32'd39, 32'd0, 32'd1}) begin
      errs++; $display("FAIL long_wait: got strobe=%0d ack/to=%0d busy=%b want 39 0 1", n, bad, busy);
    end
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        vecs++;
        if ({dat_o, tmo} !== {8'h81, 1'b0}) begin
          errs++; $display("FAIL long_wait_ack: got %h %b want 81 0", dat_o, tmo);
        end
        break;
      end
    end
    vecs++;
    if (!got) begin
      errs++; $display("FAIL long_wait_seen: got 0 want 1");
    end
    cyc = 1'b0; stb = 1'b0; rdy = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_drop_stb();
`ifdef WB_EPB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
